// File: rtl/ifu_fetch_if.sv
// Instruction-memory port of the fetch unit: a valid/ready request channel
// carrying the fetch address and a valid-only response channel carrying
// the instruction word.
interface ifu_fetch_if #(
  parameter int ISA_WIDTH = 32
);
  logic                 imem_req_valid;
  logic [ISA_WIDTH-1:0] imem_req_addr;
  logic                 imem_req_ready;
  logic                 imem_resp_valid;
  logic [31:0]          imem_resp_data;

  // Fetch unit side: issues requests, consumes responses.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  // Memory side: accepts requests, returns instruction words.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the architectural PC, fetches one word at a
// time from instruction memory, holds it for execute until commit, then
// loads the next PC. Stops permanently on ebreak, on a missing next-PC or
// on a misaligned next-PC, until reset.
module ifu_fetch #(
  parameter int                   ISA_WIDTH = 32,
  parameter logic [ISA_WIDTH-1:0] RESET_PC  = ISA_WIDTH'('h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ISA_WIDTH-1:0] pc_in,
  input  logic                 pc_w_en,
  input  logic                 commit,
  input  logic                 halt,
  output logic [ISA_WIDTH-1:0] pc_out,
  ifu_fetch_if.master          imem,
  output logic [31:0]          inst,
  output logic                 inst_valid,
  output logic                 halted,
  output logic                 misalign,
  output logic [31:0]          retired
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ISA_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]          inst_q, inst_d;
  logic                 misalign_q, misalign_d;
  logic [31:0]          retired_q, retired_d;

  // State and architectural registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      misalign_q <= 1'b0;
      retired_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

  // Next-state logic; commit and responses outside their own state are ignored.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;
    retired_d  = retired_q;
    case (state_q)
      S_REQ: begin
        if (imem.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_resp_valid) begin
          inst_d  = imem.imem_resp_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit) begin
          if (halt) begin
            // ebreak retires but keeps the PC pointing at itself.
            retired_d = retired_q + 32'd1;
            state_d   = S_HALT;
          end else if (!pc_w_en) begin
            // No next PC from execute: stop without retiring.
            state_d = S_HALT;
          end else begin
            pc_d      = pc_in;
            retired_d = retired_q + 32'd1;
            if (pc_in[1:0] != 2'b00) begin
              // The jump is taken so the bad target is visible, then stop.
              misalign_d = 1'b1;
              state_d    = S_HALT;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // Handshake and status outputs are decoded from state only.
  assign imem.imem_req_valid = (state_q == S_REQ);
  assign imem.imem_req_addr  = pc_q;
  assign inst_valid          = (state_q == S_EXEC);
  assign halted              = (state_q == S_HALT);
  assign pc_out              = pc_q;
  assign inst                = inst_q;
  assign misalign            = misalign_q;
  assign retired             = retired_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: scripted memory responder, small
// architectural model of PC/retired/misalign/halted, and a scoreboard
// queue of fetched {pc, inst} pairs checked when the DUT presents them.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_w_en;
  logic        commit;
  logic        halt;
  logic [31:0] pc_out;
  logic [31:0] inst;
  logic        inst_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] retired;

  ifu_fetch_if #(.ISA_WIDTH(32)) imem_bus ();

  ifu_fetch #(.ISA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_w_en    (pc_w_en),
    .commit     (commit),
    .halt       (halt),
    .pc_out     (pc_out),
    .imem       (imem_bus),
    .inst       (inst),
    .inst_valid (inst_valid),
    .halted     (halted),
    .misalign   (misalign),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic        exp_mis;
  logic        exp_halt;
  logic [31:0] cur_inst;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_pc   = RESET_PC;
    exp_ret  = 32'h0;
    exp_mis  = 1'b0;
    exp_halt = 1'b0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step();
    chk("rst_req_valid", 64'(imem_bus.imem_req_valid), 64'd1);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'(RESET_PC));
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    rst = 1'b0;
  endtask

  // Entered at a negedge in S_REQ; returns at a negedge in S_EXEC.
  task automatic do_fetch(input logic [31:0] data, input int req_stall,
                          input int resp_wait, input bit spur_resp, input bit spur_commit);
    chk("req_valid", 64'(imem_bus.imem_req_valid), 64'd1);
    chk("req_addr", 64'(imem_bus.imem_req_addr), 64'(exp_pc));
    for (int i = 0; i < req_stall; i++) begin
      imem_bus.imem_req_ready  = 1'b0;
      imem_bus.imem_resp_valid = spur_resp;
      imem_bus.imem_resp_data  = 32'hDEAD_BEEF;
      step();
      chk("stall_addr", 64'(imem_bus.imem_req_addr), 64'(exp_pc));
      chk("stall_req_valid", 64'(imem_bus.imem_req_valid), 64'd1);
      chk("stall_inst_valid", 64'(inst_valid), 64'd0);
    end
    imem_bus.imem_req_ready  = 1'b1;
    imem_bus.imem_resp_valid = 1'b0;
    step();
    imem_bus.imem_req_ready = 1'b0;
    for (int i = 0; i < resp_wait; i++) begin
      commit  = spur_commit && (i == 0);
      pc_w_en = commit;
      pc_in   = 32'h1234_5678;
      step();
      commit  = 1'b0;
      pc_w_en = 1'b0;
      chk("wait_req_valid", 64'(imem_bus.imem_req_valid), 64'd0);
      chk("wait_inst_valid", 64'(inst_valid), 64'd0);
      chk("wait_pc", 64'(pc_out), 64'(exp_pc));
      chk("wait_retired", 64'(retired), 64'(exp_ret));
    end
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_data  = data;
    sb.push_back({exp_pc, data});
    step();
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data  = 32'h0;
    chk("exec_inst_valid", 64'(inst_valid), 64'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      logic [63:0] e;
      e = sb.pop_front();
      cur_inst = e[31:0];
      chk("exec_inst", 64'(inst), 64'(e[31:0]));
      chk("exec_pc", 64'(pc_out), 64'(e[63:32]));
    end
  endtask

  // Entered at a negedge in S_EXEC; applies stall cycles then one commit.
  task automatic do_commit(input int stall, input logic h, input logic wen,
                           input logic [31:0] npc);
    for (int i = 0; i < stall; i++) begin
      step();
      chk("xstall_inst", 64'(inst), 64'(cur_inst));
      chk("xstall_pc", 64'(pc_out), 64'(exp_pc));
      chk("xstall_inst_valid", 64'(inst_valid), 64'd1);
      chk("xstall_req_valid", 64'(imem_bus.imem_req_valid), 64'd0);
    end
    commit  = 1'b1;
    halt    = h;
    pc_w_en = wen;
    pc_in   = npc;
    step();
    commit  = 1'b0;
    halt    = 1'b0;
    pc_w_en = 1'b0;
    if (h) begin
      exp_ret  = exp_ret + 32'd1;
      exp_halt = 1'b1;
    end else if (!wen) begin
      exp_halt = 1'b1;
    end else begin
      exp_pc  = npc;
      exp_ret = exp_ret + 32'd1;
      if (npc[1:0] != 2'b00) begin
        exp_mis  = 1'b1;
        exp_halt = 1'b1;
      end
    end
    chk("cm_pc", 64'(pc_out), 64'(exp_pc));
    chk("cm_retired", 64'(retired), 64'(exp_ret));
    chk("cm_misalign", 64'(misalign), 64'(exp_mis));
    chk("cm_halted", 64'(halted), 64'(exp_halt));
    chk("cm_req_valid", 64'(imem_bus.imem_req_valid), 64'(!exp_halt));
    chk("cm_inst_valid", 64'(inst_valid), 64'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pc_in = 32'h0;
    pc_w_en = 1'b0;
    commit = 1'b0;
    halt = 1'b0;
    imem_bus.imem_req_ready  = 1'b0;
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data  = 32'h0;
    cur_inst = 32'h0;
    model_reset();
    do_reset();

    // First fetch at minimum period.
    do_fetch(32'h0010_0093, 0, 0, 1'b0, 1'b0);
    do_commit(0, 1'b0, 1'b1, 32'h8000_0004);

    // Request back-pressure with ignored responses, then a late response.
    do_fetch(32'h0020_0113, 5, 3, 1'b1, 1'b0);
    do_commit(0, 1'b0, 1'b1, 32'h8000_0008);

    // Spurious commit while waiting, then a long execute stall.
    do_fetch(32'h0030_0193, 0, 2, 1'b0, 1'b1);
    do_commit(10, 1'b0, 1'b1, 32'h8000_000C);

    // Retired counter wrap.
    do_fetch(32'h0040_0213, 0, 0, 1'b0, 1'b0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    do_commit(0, 1'b0, 1'b1, 32'h8000_0010);
    chk("wrap_retired", 64'(retired), 64'd0);

    // Asynchronous reset in S_WAIT, stale response right after release.
    imem_bus.imem_req_ready = 1'b1;
    step();
    imem_bus.imem_req_ready = 1'b0;
    chk("mid_in_wait", 64'(imem_bus.imem_req_valid), 64'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_pc", 64'(pc_out), 64'(RESET_PC));
    chk("async_req_valid", 64'(imem_bus.imem_req_valid), 64'd1);
    chk("async_inst_valid", 64'(inst_valid), 64'd0);
    chk("async_retired", 64'(retired), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_bus.imem_resp_valid = 1'b1;
    imem_bus.imem_resp_data  = 32'hBADC_0DE0;
    step();
    imem_bus.imem_resp_valid = 1'b0;
    imem_bus.imem_resp_data  = 32'h0;
    chk("stale_inst", 64'(inst), 64'd0);
    chk("stale_inst_valid", 64'(inst_valid), 64'd0);
    chk("stale_req_valid", 64'(imem_bus.imem_req_valid), 64'd1);
    chk("stale_pc", 64'(pc_out), 64'(RESET_PC));

    // Misaligned jump.
    do_fetch(32'h0000_0067, 0, 0, 1'b0, 1'b0);
    do_commit(0, 1'b0, 1'b1, 32'h8000_0006);
    chk("mis_pc", 64'(pc_out), 64'h8000_0006);
    do_reset();

    // Illegal next-PC.
    do_fetch(32'h0000_0013, 0, 1, 1'b0, 1'b0);
    do_commit(2, 1'b0, 1'b0, 32'h8000_0004);
    chk("ill_pc", 64'(pc_out), 64'(RESET_PC));
    do_reset();

    // ebreak, then the unit must stay quiet.
    do_fetch(32'h0010_0073, 0, 0, 1'b0, 1'b0);
    do_commit(0, 1'b1, 1'b1, 32'h8000_0010);
    for (int i = 0; i < 20; i++) begin
      imem_bus.imem_req_ready  = 1'b1;
      imem_bus.imem_resp_valid = i[0];
      commit  = ~i[0];
      pc_w_en = 1'b1;
      pc_in   = 32'h8000_0020;
      step();
      chk("hlt_req_valid", 64'(imem_bus.imem_req_valid), 64'd0);
      chk("hlt_halted", 64'(halted), 64'd1);
      chk("hlt_pc", 64'(pc_out), 64'(RESET_PC));
      chk("hlt_retired", 64'(retired), 64'(exp_ret));
    end
    commit = 1'b0;
    pc_w_en = 1'b0;
    imem_bus.imem_req_ready  = 1'b0;
    imem_bus.imem_resp_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
